// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter. Written words are queued in a FIFO and sent as
// back-to-back frames with configurable data width, parity and stop bits.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic                        Wr_En,
    input  logic [DATA_BITS-1:0]        Wr_Data,
    output logic                        Full,
    output logic                        Empty,
    output logic [$clog2(FIFO_DEPTH):0] Count,
    output logic                        Overflow,
    output logic                        Tx_Serial,
    output logic                        Tx_Active,
    output logic                        Tx_Done
);
    // state    | meaning
    // S_IDLE   | line high, waiting for a queued word
    // S_START  | start bit (low)
    // S_DATA   | data bits, LSB first
    // S_PARITY | parity bit (only when PARITY != 0)
    // S_STOP   | stop bit(s) (high); Tx_Done on the final clock

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int IW = 4;

    if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
        PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
        $error("uart_tx_fifo: illegal parameter value");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [AW:0]          count_q, count_d;
    logic                 fifo_full, fifo_empty, push, pop;
    logic [DATA_BITS-1:0] head;
    logic                 head_par;

    state_t               state_q;
    logic [BW-1:0]        baud_q;
    logic [IW-1:0]        bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 parity_q, serial_q, active_q, done_q, overflow_q;
    logic                 last_clk, last_data, last_stop;

    assign fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push       = Wr_En && !fifo_full;
    assign head       = mem_q[rd_ptr_q];
    assign head_par   = (PARITY == 2) ? ^head : ~(^head);

    assign last_clk  = (baud_q == BW'(CLKS_PER_BIT - 1));
    assign last_data = (bit_q == IW'(DATA_BITS - 1));
    assign last_stop = (bit_q == IW'(STOP_BITS - 1));

    // Pop either from idle or on the final stop clock so frames chain with no gap.
    assign pop = !fifo_empty &&
                 ((state_q == S_IDLE) || (state_q == S_STOP && last_clk && last_stop));

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= Wr_Data;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q    <= count_d;
            overflow_q <= Wr_En && fifo_full;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            serial_q <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        state_q  <= S_START;
                        shift_q  <= head;
                        parity_q <= head_par;
                        baud_q   <= '0;
                        serial_q <= 1'b0;
                        active_q <= 1'b1;
                    end
                end
                S_START: begin
                    if (last_clk) begin
                        state_q  <= S_DATA;
                        baud_q   <= '0;
                        bit_q    <= '0;
                        serial_q <= shift_q[0];
                        shift_q  <= shift_q >> 1;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (last_clk) begin
                        baud_q <= '0;
                        if (last_data) begin
                            bit_q <= '0;
                            if (PARITY != 0) begin
                                state_q  <= S_PARITY;
                                serial_q <= parity_q;
                            end else begin
                                state_q  <= S_STOP;
                                serial_q <= 1'b1;
                            end
                        end else begin
                            bit_q    <= bit_q + 1'b1;
                            serial_q <= shift_q[0];
                            shift_q  <= shift_q >> 1;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (last_clk) begin
                        state_q  <= S_STOP;
                        baud_q   <= '0;
                        bit_q    <= '0;
                        serial_q <= 1'b1;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                S_STOP: begin
                    // Registered pulse: raise it one clock early so it lands on the final clock.
                    if (last_stop && baud_q == BW'(CLKS_PER_BIT - 2)) begin
                        done_q <= 1'b1;
                    end
                    if (last_clk) begin
                        baud_q <= '0;
                        if (!last_stop) begin
                            bit_q <= bit_q + 1'b1;
                        end else if (pop) begin
                            state_q  <= S_START;
                            shift_q  <= head;
                            parity_q <= head_par;
                            serial_q <= 1'b0;
                        end else begin
                            state_q  <= S_IDLE;
                            serial_q <= 1'b1;
                            active_q <= 1'b0;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    serial_q <= 1'b1;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign Full      = fifo_full;
    assign Empty     = fifo_empty;
    assign Count     = count_q;
    assign Overflow  = overflow_q;
    assign Tx_Serial = serial_q;
    assign Tx_Active = active_q;
    assign Tx_Done   = done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: four instances (8N1, 8E1, 8O1, 7N2) at 4 clocks per bit,
// fixed frame vectors, back-to-back/overflow bursts and a mid-frame reset.
module tb_uart_tx_fifo;
    localparam int CPB = 4;

    typedef struct {
        int          inst;
        logic [7:0]  word;
        int          nbits;
        logic [15:0] line;
    } vec_t;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       wr_en   [4];
    logic [7:0] wr_data [4];
    logic       full [4], empty [4], ovf [4], ser [4], act [4], done [4];
    logic [4:0] cnt  [4];

    int checks = 0;
    int errors = 0;
    logic [7:0] wr_q  [$];
    logic       exp_q [$];

    always #5 Clk = ~Clk;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u_8n1 (
        .Clk(Clk), .Rst(Rst), .Wr_En(wr_en[0]), .Wr_Data(wr_data[0]),
        .Full(full[0]), .Empty(empty[0]), .Count(cnt[0]), .Overflow(ovf[0]),
        .Tx_Serial(ser[0]), .Tx_Active(act[0]), .Tx_Done(done[0]));

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) u_8e1 (
        .Clk(Clk), .Rst(Rst), .Wr_En(wr_en[1]), .Wr_Data(wr_data[1]),
        .Full(full[1]), .Empty(empty[1]), .Count(cnt[1]), .Overflow(ovf[1]),
        .Tx_Serial(ser[1]), .Tx_Active(act[1]), .Tx_Done(done[1]));

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) u_8o1 (
        .Clk(Clk), .Rst(Rst), .Wr_En(wr_en[2]), .Wr_Data(wr_data[2]),
        .Full(full[2]), .Empty(empty[2]), .Count(cnt[2]), .Overflow(ovf[2]),
        .Tx_Serial(ser[2]), .Tx_Active(act[2]), .Tx_Done(done[2]));

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(16)) u_7n2 (
        .Clk(Clk), .Rst(Rst), .Wr_En(wr_en[3]), .Wr_Data(wr_data[3][6:0]),
        .Full(full[3]), .Empty(empty[3]), .Count(cnt[3]), .Overflow(ovf[3]),
        .Tx_Serial(ser[3]), .Tx_Active(act[3]), .Tx_Done(done[3]));

    function automatic int db_of(input int inst);
        return (inst == 3) ? 7 : 8;
    endfunction

    function automatic int par_of(input int inst);
        case (inst)
            1:       return 2;
            2:       return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int sb_of(input int inst);
        return (inst == 3) ? 2 : 1;
    endfunction

    function automatic int fbits_of(input int inst);
        return 1 + db_of(inst) + ((par_of(inst) != 0) ? 1 : 0) + sb_of(inst);
    endfunction

    // Reference frame: start, data LSB first, parity from a ones count, stop bits.
    function void push_frame(input int inst, input logic [7:0] w);
        int ones;
        ones = 0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < db_of(inst); i++) begin
            exp_q.push_back(w[i]);
            ones += int'(w[i]);
        end
        if (par_of(inst) == 2) exp_q.push_back((ones % 2) == 1);
        else if (par_of(inst) == 1) exp_q.push_back((ones % 2) == 0);
        for (int i = 0; i < sb_of(inst); i++) exp_q.push_back(1'b1);
    endfunction

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Writes wr_q on consecutive cycles from an empty FIFO and checks the line
    // cycle by cycle against exp_q (frames start 2 cycles after the first write).
    task automatic run_seq(input int inst, input string name);
        int n, fclk, lclk, bad, n_ovf, n_acc, exp_cnt, f;
        logic e_ser, e_act, e_done;
        n     = wr_q.size();
        fclk  = fbits_of(inst) * CPB;
        lclk  = exp_q.size() * CPB;
        bad   = 0;
        n_ovf = 0;
        n_acc = (n > 17) ? 17 : n;
        for (int c = 0; c < n + lclk + 4; c++) begin
            @(negedge Clk);
            f = c - 2;
            if (f >= 0 && f < lclk) begin
                e_ser  = exp_q[f / CPB];
                e_act  = 1'b1;
                e_done = ((f % fclk) == fclk - 1);
            end else begin
                e_ser  = 1'b1;
                e_act  = 1'b0;
                e_done = 1'b0;
            end
            if (ser[inst] !== e_ser || act[inst] !== e_act || done[inst] !== e_done) bad++;
            if (ovf[inst] === 1'b1) n_ovf++;
            if (c == n) begin
                exp_cnt = (n == 1) ? 1 : n_acc - 1;
                chk({name, " count"}, int'(cnt[inst]), exp_cnt);
                chk({name, " full"}, int'(full[inst]), int'(exp_cnt == 16));
                chk({name, " overflow_now"}, int'(ovf[inst]), int'(n > 17));
            end
            wr_en[inst]   = (c < n);
            wr_data[inst] = (c < n) ? wr_q[c] : 8'($urandom);
        end
        wr_en[inst] = 1'b0;
        chk({name, " line_bad_cycles"}, bad, 0);
        chk({name, " overflow_pulses"}, n_ovf, (n > 17) ? n - 17 : 0);
        chk({name, " empty_end"}, int'(empty[inst]), 1);
        chk({name, " count_end"}, int'(cnt[inst]), 0);
    endtask

    initial begin
        vec_t tbl [10];
        int   inst, n, bad;
        logic [7:0] w;

        tbl[0] = '{0, 8'h67, 10, 16'({1'b1, 8'h67, 1'b0})};
        tbl[1] = '{1, 8'h67, 11, 16'({1'b1, 1'b1, 8'h67, 1'b0})};
        tbl[2] = '{2, 8'h67, 11, 16'({1'b1, 1'b0, 8'h67, 1'b0})};
        tbl[3] = '{3, 8'h55, 10, 16'({2'b11, 7'h55, 1'b0})};
        tbl[4] = '{0, 8'h00, 10, 16'({1'b1, 8'h00, 1'b0})};
        tbl[5] = '{1, 8'h00, 11, 16'({1'b1, 1'b0, 8'h00, 1'b0})};
        tbl[6] = '{2, 8'h01, 11, 16'({1'b1, 1'b0, 8'h01, 1'b0})};
        tbl[7] = '{3, 8'h7F, 10, 16'({2'b11, 7'h7F, 1'b0})};
        tbl[8] = '{1, 8'h80, 11, 16'({1'b1, 1'b1, 8'h80, 1'b0})};
        tbl[9] = '{2, 8'h00, 11, 16'({1'b1, 1'b1, 8'h00, 1'b0})};

        Rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_en[i]   = 1'b0;
            wr_data[i] = 8'h00;
        end
        repeat (3) @(negedge Clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst%0d serial", i), int'(ser[i]), 1);
            chk($sformatf("rst%0d active", i), int'(act[i]), 0);
            chk($sformatf("rst%0d done", i), int'(done[i]), 0);
            chk($sformatf("rst%0d overflow", i), int'(ovf[i]), 0);
            chk($sformatf("rst%0d count", i), int'(cnt[i]), 0);
            chk($sformatf("rst%0d empty", i), int'(empty[i]), 1);
            chk($sformatf("rst%0d full", i), int'(full[i]), 0);
        end
        Rst = 1'b0;
        @(negedge Clk);

        for (int i = 0; i < 10; i++) begin
            wr_q.delete();
            exp_q.delete();
            wr_q.push_back(tbl[i].word);
            for (int k = 0; k < tbl[i].nbits; k++) exp_q.push_back(tbl[i].line[k]);
            run_seq(tbl[i].inst, $sformatf("vec%0d", i));
        end

        wr_q = '{8'hA5, 8'h3C, 8'hFF};
        exp_q.delete();
        foreach (wr_q[j]) push_frame(0, wr_q[j]);
        run_seq(0, "b2b");

        for (int r = 0; r < 8; r++) begin
            inst = r % 4;
            n    = $urandom_range(1, 4);
            wr_q.delete();
            exp_q.delete();
            for (int j = 0; j < n; j++) begin
                w = 8'($urandom_range(0, (1 << db_of(inst)) - 1));
                wr_q.push_back(w);
                push_frame(inst, w);
            end
            run_seq(inst, $sformatf("rand%0d", r));
        end

        wr_q.delete();
        exp_q.delete();
        for (int j = 0; j < 18; j++) begin
            w = 8'($urandom);
            wr_q.push_back(w);
            if (j < 17) push_frame(0, w);
        end
        run_seq(0, "overflow");

        // Reset during the second data bit of a zero word, three words still queued.
        for (int c = 0; c <= 12; c++) begin
            @(negedge Clk);
            if (c < 12) begin
                wr_en[0]   = (c < 4);
                wr_data[0] = 8'(c * 17);
            end
        end
        chk("pre_rst serial", int'(ser[0]), 0);
        chk("pre_rst active", int'(act[0]), 1);
        chk("pre_rst count", int'(cnt[0]), 3);
        #2 Rst = 1'b1;
        #1;
        chk("async_rst serial", int'(ser[0]), 1);
        chk("async_rst active", int'(act[0]), 0);
        chk("async_rst count", int'(cnt[0]), 0);
        chk("async_rst empty", int'(empty[0]), 1);
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        bad = 0;
        repeat (60) begin
            @(negedge Clk);
            if (ser[0] !== 1'b1 || act[0] !== 1'b0 || done[0] !== 1'b0 || cnt[0] !== 5'd0) bad++;
        end
        chk("post_rst idle_bad_cycles", bad, 0);
        wr_q = '{8'h5A};
        exp_q.delete();
        push_frame(0, 8'h5A);
        run_seq(0, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised successor to the fixed 8N1 UART transmit path: buffered serial transmitter with configurable data width, parity and stop bits.
- Writes enter an internal FIFO; a frame FSM drains the FIFO and serialises each word onto Tx_Serial.
- Sits between the host-side byte producer and the line.
- Lets software queue bursts without polling Tx_Done between words.

Parameters:
- CLKS_PER_BIT, 10417: clocks per bit period (100 MHz / 9600 baud); legal >= 2.
- DATA_BITS, 8: data bits per frame; legal 5..9.
- PARITY, 0: parity mode; 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: stop bits per frame; legal 1 or 2.
- FIFO_DEPTH, 16: FIFO entries; power of 2, >= 2.

Ports:
- Clk  in  1  system clock; all logic on the rising edge.
- Rst  in  1  asynchronous, active-high reset.
- Wr_En  in  1  write strobe; one word accepted per cycle when permitted.
- Wr_Data  in  DATA_BITS  word to queue.
- Full  out  1  Count == FIFO_DEPTH.
- Empty  out  1  Count == 0.
- Count  out  $clog2(FIFO_DEPTH)+1  words stored; excludes the word currently on the line.
- Overflow  out  1  one-cycle pulse when a write is dropped.
- Tx_Serial  out  1  serial line; idle high.
- Tx_Active  out  1  high for every clock from the first start-bit clock to the last stop-bit clock.
- Tx_Done  out  1  one-cycle pulse on the last clock of each frame's final stop bit.

Behaviour:
- Reset (async assert; release synchronous to Clk):
  - Tx_Serial=1; Tx_Active=0; Tx_Done=0; Overflow=0.
  - Count=0; Empty=1; Full=0.
  - FSM=IDLE; FIFO pointers cleared; stored data discarded.
- Reset mid-frame: Tx_Serial goes high immediately; the partial frame is abandoned and never resumed.
- FIFO write:
  - Wr_En && !Full: word stored; Count increments on the next edge.
  - Wr_En && Full: word dropped; Overflow=1 on the next cycle; contents unchanged.
  - A pop in the same cycle does NOT rescue a write while Full.
  - Simultaneous accepted write and pop: Count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- A single baud counter counts 0..CLKS_PER_BIT-1; bit index counts data bits and stop bits.
- IDLE:
  - Tx_Serial=1.
  - If !Empty: pop the head word into the shift register; enter START next cycle.
  - A word written into an empty FIFO therefore starts its frame 2 cycles after the Wr_En cycle.
- START: Tx_Serial=0 for CLKS_PER_BIT clocks.
- DATA: DATA_BITS bits, LSB first, CLKS_PER_BIT clocks each.
- PARITY (skipped when PARITY=0), CLKS_PER_BIT clocks:
  - even mode: bit = XOR of the data bits.
  - odd mode: bit = inverted XOR of the data bits.
- STOP:
  - Tx_Serial=1 for STOP_BITS*CLKS_PER_BIT clocks.
  - Tx_Done pulses on the final clock.
  - On that final clock: if !Empty, pop and go directly to START (zero idle gap; Tx_Active stays high); else go to IDLE.
- Frame length is exactly (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT clocks.
- Wr_Data is captured at write; later changes to Wr_Data do not affect queued words.
- Illegal parameter values: elaboration-time error, not runtime behaviour.

Test Plan:
- Frame timing, 8N1, CLKS_PER_BIT=4: write 0x67 into an empty FIFO.
  - Line: start 0, then 1,1,1,0,0,1,1,0, then stop 1; each bit 4 clocks.
  - Tx_Active high for exactly 40 clocks; one Tx_Done pulse on clock 40.
- Parity, PARITY=2, then PARITY=1: send 0x67 (five ones).
  - Even: parity bit 1; odd: parity bit 0.
  - Frame is 44 clocks.
- Back-to-back: write 0xA5, 0x3C, 0xFF on consecutive cycles, 8N1, CLKS_PER_BIT=4.
  - Tx_Active continuously high for 120 clocks.
  - Three Tx_Done pulses, 40 clocks apart.
  - Data order preserved.
- Overflow, FIFO_DEPTH=16: write 18 words on consecutive cycles starting from empty.
  - Word 1 popped; words 2-17 stored; Count=16, Full=1.
  - Word 18 dropped; exactly one Overflow pulse.
  - 17 frames transmitted in order; Empty=1 at the end.
- Frame format, DATA_BITS=7, STOP_BITS=2, PARITY=0: send 0x55.
  - Line: 0, then 1,0,1,0,1,0,1, then 1,1.
  - Frame is 10*CLKS_PER_BIT clocks.
- Reset mid-frame: assert Rst during DATA with 3 words queued.
  - Tx_Serial=1 without waiting for a clock edge; Count=0; no Tx_Done pulse.
  - After release: line stays idle until a new write.
